// File: rtl/flu_fp_pkg.sv
// flu_fp_pkg: shared types, flag indices and IEEE pattern helpers for the FLU add/sub unit
// Contents: FSM state enum, operand class enum, flag bit indices,
// canonical qNaN / largest-finite pattern builders, operand classifier.
package flu_fp_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    typedef enum logic [2:0] {FP_ZERO, FP_SUBN, FP_NORM, FP_INF, FP_QNAN, FP_SNAN} fp_class_t;

    localparam int INVALID   = 3;
    localparam int OVERFLOW  = 2;
    localparam int UNDERFLOW = 1;
    localparam int INEXACT   = 0;

    // Patterns are built 64 bits wide; callers keep the low 1+ew+mw bits.
    function automatic logic [63:0] qnan_pat(input int ew, input int mw);
        logic [63:0] e;
        e = (64'd1 << ew) - 64'd1;
        return (e << mw) | (64'd1 << (mw - 1));
    endfunction

    function automatic logic [63:0] max_finite(input int ew, input int mw);
        logic [63:0] e;
        e = (64'd1 << ew) - 64'd1;
        return ((e - 64'd1) << mw) | ((64'd1 << mw) - 64'd1);
    endfunction

    function automatic fp_class_t fp_classify(input logic e_ones, input logic e_zero,
                                              input logic f_zero, input logic f_msb);
        return e_zero ? (f_zero ? FP_ZERO : FP_SUBN) :
               !e_ones ? FP_NORM :
               f_zero  ? FP_INF  :
               f_msb   ? FP_QNAN : FP_SNAN;
    endfunction

endpackage

// File: rtl/flu_lzc.sv
// flu_lzc: parametrised leading-zero counter
// Ports: x (W-bit input), cnt (number of leading zeros, W when x is zero)
module flu_lzc #(
    parameter  int W  = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (x[i]) cnt = CW'(W - 1 - i);
    end

endmodule

// File: rtl/flu_fp_addsub.sv
// flu_fp_addsub: handshaked multi-cycle IEEE floating-point add/subtract unit
// Ports: clock, reset_n (async active-low); in_valid/in_ready, op_sub, a, b, tag_in
// on the request side; out_valid/out_ready, result, tag_out, flags
// {invalid, overflow, underflow, inexact} on the response side.
// Build option: FLU_FP_RNE_EN selects round-to-nearest-even, otherwise truncation.
module flu_fp_addsub
    import flu_fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int TAG_W = 5,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [TAG_W-1:0] tag_out,
    output logic [3:0]       flags
);

    localparam int SW = MAN_W + 4;
    localparam int CW = $clog2(SW + 1);
    localparam int EW = EXP_W + 1;
    localparam logic [63:0] QN64 = qnan_pat(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QN64[W-1:0];
    localparam logic [EW-1:0] EMAX = {1'b0, {EXP_W{1'b1}}};

    state_t state, state_nx;

    logic [W-1:0]     ra, rb;
    logic             rop;
    logic [TAG_W-1:0] rtag;

    logic [SW-1:0]    sig_b, sig_s;
    logic [EXP_W-1:0] exp_r;
    logic             sgn_r, sub_r;
    logic             spec_r;
    logic [W-1:0]     spec_res_r;
    logic [3:0]       spec_flg_r;
    logic [SW:0]      sum_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ALIGN : IDLE;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // ALIGN: order by full magnitude, align the smaller significand, classify specials
    logic [EXP_W-1:0] ea, eb, be, se, bee, see, diff, shamt;
    logic [MAN_W-1:0] fa, fb;
    logic             sa, sbe, a_big, bsgn, ssgn;
    logic [W-2:0]     big_w, sml_w;
    logic [SW-1:0]    big_sig, sml_sig, shifted, sml_al;
    logic             stk;
    fp_class_t        ca, cb;
    logic             nan_a, nan_b, inf_a, inf_b, inf_inv;
    logic             a_spec;
    logic [W-1:0]     a_spec_res;
    logic [3:0]       a_spec_flg;

    always_comb begin
        ea      = ra[W-2:MAN_W];
        eb      = rb[W-2:MAN_W];
        fa      = ra[MAN_W-1:0];
        fb      = rb[MAN_W-1:0];
        sa      = ra[W-1];
        sbe     = rb[W-1] ^ rop;
        a_big   = ra[W-2:0] >= rb[W-2:0];
        big_w   = a_big ? ra[W-2:0] : rb[W-2:0];
        sml_w   = a_big ? rb[W-2:0] : ra[W-2:0];
        bsgn    = a_big ? sa : sbe;
        ssgn    = a_big ? sbe : sa;
        be      = big_w[W-2:MAN_W];
        se      = sml_w[W-2:MAN_W];
        bee     = (be == '0) ? EXP_W'(1) : be;
        see     = (se == '0) ? EXP_W'(1) : se;
        big_sig = {|be, big_w[MAN_W-1:0], 3'b000};
        sml_sig = {|se, sml_w[MAN_W-1:0], 3'b000};
        diff    = bee - see;
        shamt   = (diff > EXP_W'(SW - 1)) ? EXP_W'(SW - 1) : diff;
        shifted = sml_sig >> shamt;
        stk     = |(sml_sig & ~({SW{1'b1}} << shamt));
        sml_al  = {shifted[SW-1:1], shifted[0] | stk};
        ca      = fp_classify(&ea, ~|ea, ~|fa, fa[MAN_W-1]);
        cb      = fp_classify(&eb, ~|eb, ~|fb, fb[MAN_W-1]);
        nan_a   = (ca == FP_QNAN) || (ca == FP_SNAN);
        nan_b   = (cb == FP_QNAN) || (cb == FP_SNAN);
        inf_a   = (ca == FP_INF);
        inf_b   = (cb == FP_INF);
        inf_inv = inf_a & inf_b & (sa ^ sbe);
        a_spec  = nan_a | nan_b | inf_a | inf_b;
        a_spec_res = (nan_a | nan_b | inf_inv) ? QNAN :
                     inf_a ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                             {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        a_spec_flg = '0;
        a_spec_flg[INVALID] = (ca == FP_SNAN) | (cb == FP_SNAN) | inf_inv;
    end

    // NORM: normalise, round, detect overflow and assemble the result word
    logic [CW-1:0]    lz;
    logic [EW-1:0]    lz_e, lim, sh, e_l, e0, e1;
    logic [SW-1:0]    m_l, m;
    logic             inc, cy, ovf, unf, inx, zero;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     ovf_res, n_res;
    logic [3:0]       n_flg;

    flu_lzc #(.W(SW)) u_lzc (.x(sum_r[SW-1:0]), .cnt(lz));

    always_comb begin
        lz_e = EW'(lz);
        lim  = {1'b0, exp_r} - EW'(1);
        sh   = (lz_e < lim) ? lz_e : lim;
        m_l  = sum_r[SW-1:0] << sh;
        e_l  = {1'b0, exp_r} - sh;
        m    = sum_r[SW] ? {sum_r[SW:2], sum_r[1] | sum_r[0]} : m_l;
        e0   = sum_r[SW] ? {1'b0, exp_r} + EW'(1) : (m_l[SW-1] ? e_l : '0);
`ifdef FLU_FP_RNE_EN
        inc     = m[2] & (m[1] | m[0] | m[3]);
        ovf_res = {sgn_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
        inc     = 1'b0;
        ovf_res = {sgn_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
        mant  = {1'b0, m[SW-1:3]} + (MAN_W+2)'(inc);
        cy    = mant[MAN_W+1];
        // a subnormal that rounds up into the hidden bit becomes the smallest normal
        e1    = e0 + EW'(cy) + EW'((e0 == '0) && mant[MAN_W]);
        frac  = cy ? '0 : mant[MAN_W-1:0];
        ovf   = e1 >= EMAX;
        inx   = (|m[2:0]) | ovf;
        unf   = (e1 == '0) & inx;
        zero  = ~|m;
        n_res = spec_r ? spec_res_r :
                ovf    ? ovf_res :
                zero   ? {sgn_r & ~sub_r, {(W-1){1'b0}}} :
                         {sgn_r, e1[EXP_W-1:0], frac};
        n_flg = '0;
        n_flg[OVERFLOW]  = ovf;
        n_flg[UNDERFLOW] = unf;
        n_flg[INEXACT]   = inx;
        n_flg = spec_r ? spec_flg_r : n_flg;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            ra         <= '0;
            rb         <= '0;
            rop        <= 1'b0;
            rtag       <= '0;
            sig_b      <= '0;
            sig_s      <= '0;
            exp_r      <= '0;
            sgn_r      <= 1'b0;
            sub_r      <= 1'b0;
            spec_r     <= 1'b0;
            spec_res_r <= '0;
            spec_flg_r <= '0;
            sum_r      <= '0;
            result     <= '0;
            tag_out    <= '0;
            flags      <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                ra   <= a;
                rb   <= b;
                rop  <= op_sub;
                rtag <= tag_in;
            end
            if (state == ALIGN) begin
                sig_b      <= big_sig;
                sig_s      <= sml_al;
                exp_r      <= bee;
                sgn_r      <= bsgn;
                sub_r      <= bsgn ^ ssgn;
                spec_r     <= a_spec;
                spec_res_r <= a_spec_res;
                spec_flg_r <= a_spec_flg;
            end
            if (state == ADD)
                sum_r <= sub_r ? {1'b0, sig_b} - {1'b0, sig_s} : {1'b0, sig_b} + {1'b0, sig_s};
            if (state == NORM) begin
                result  <= n_res;
                flags   <= n_flg;
                tag_out <= rtag;
            end
        end

endmodule

// File: tb/tb_flu_fp_addsub.sv
// tb_flu_fp_addsub: table-driven scoreboard bench for flu_fp_addsub (single precision)
module tb_flu_fp_addsub;

`ifdef FLU_FP_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic [4:0]  t;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic [3:0]  flags;

    exp_t q[$];
    vec_t tv[$];
    int   nvec = 0;
    int   nbad = 0;
    logic [4:0] tag_ctr = 5'd1;

    flu_fp_addsub dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .tag_out(tag_out), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic offer(input logic op, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] er, input logic [3:0] ef);
        @(negedge clock);
        chk("in_ready idle", 32'(in_ready), 32'd1);
        op_sub   = op;
        a        = xa;
        b        = xb;
        tag_in   = tag_ctr;
        in_valid = 1'b1;
        q.push_back('{er, ef, tag_ctr});
        tag_ctr  = tag_ctr + 5'd1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clock);
            #1 lat++;
        end
    endtask

    task automatic compare_out(input string nm);
        exp_t e;
        if (q.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL %s: output with empty scoreboard", nm);
        end else begin
            e = q.pop_front();
            chk({nm, " result"}, result, e.r);
            chk({nm, " flags"}, 32'(flags), 32'(e.f));
            chk({nm, " tag"}, 32'(tag_out), 32'(e.t));
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        offer(v.op, v.a, v.b, v.r, v.f);
        chk({nm, " in_ready busy"}, 32'(in_ready), 32'd0);
        wait_out(lat);
        chk({nm, " latency"}, 32'(lat), 32'd3);
        compare_out(nm);
        @(posedge clock);
        #1 chk({nm, " released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        bit ok;
        exp_t hold;
        tv.push_back('{1'b0, 32'h40800000, 32'h40A00000, 32'h41100000, 4'h0});
        tv.push_back('{1'b1, 32'h40A00000, 32'h40800000, 32'h3F800000, 4'h0});
        tv.push_back('{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0});
        tv.push_back('{1'b0, 32'h3F800001, 32'h33800000, RNE ? 32'h3F800002 : 32'h3F800001, 4'h1});
        tv.push_back('{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'h5});
        tv.push_back('{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8});
        tv.push_back('{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8});
        tv.push_back('{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0});
        tv.push_back('{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'h0});
        tv.push_back('{1'b1, 32'h3F800000, 32'hFF800000, 32'h7F800000, 4'h0});
        tv.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0});
        tv.push_back('{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 4'h0});
        tv.push_back('{1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'h0});
        tv.push_back('{1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 4'h0});
        tv.push_back('{1'b1, 32'h00800000, 32'h00000001, 32'h007FFFFF, 4'h0});
        tv.push_back('{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0});
        tv.push_back('{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'h0});
        tv.push_back('{1'b0, 32'h3F800000, 32'h00000001, 32'h3F800000, 4'h1});
        tv.push_back('{1'b0, 32'h3F800000, 32'h33800001, RNE ? 32'h3F800001 : 32'h3F800000, 4'h1});
        tv.push_back('{1'b0, 32'h3FFFFFFF, 32'h33800000, RNE ? 32'h40000000 : 32'h3FFFFFFF, 4'h1});

        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset tag", 32'(tag_out), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b1;
        @(posedge clock);
        #1 chk("ignored in reset", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tv[i]) run_vec(tv[i], $sformatf("vec%0d", i));

        // backpressure: result held while out_ready low, offered op not accepted
        out_ready = 1'b0;
        offer(1'b0, 32'h40800000, 32'h40A00000, 32'h41100000, 4'h0);
        wait_out(lat);
        chk("bp latency", 32'(lat), 32'd3);
        hold = q[0];
        @(negedge clock);
        op_sub = 1'b0;
        a = 32'h3F800000;
        b = 32'h3F800000;
        tag_in = 5'd30;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp result", result, hold.r);
            chk("bp tag", 32'(tag_out), 32'(hold.t));
        end
        @(negedge clock);
        in_valid = 1'b0;
        compare_out("bp");
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) ok = 1'b0;
            @(posedge clock);
            #1;
        end
        chk("bp no extra op", 32'(ok), 32'd1);

        // reset asserted while the operation is in ADD
        offer(1'b0, 32'h40800000, 32'h40A00000, 32'h41100000, 4'h0);
        @(posedge clock);
        #1 reset_n = 1'b0;
        void'(q.pop_back());
        #1 chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1 if (out_valid) ok = 1'b0;
        end
        chk("rst no partial", 32'(ok), 32'd1);
        chk("rst cleared result", result, 32'd0);
        run_vec(tv[1], "post reset");
        chk("scoreboard empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
